// File: rtl/mcif_rsp_route2.sv
// Return-path router for the 2-port MCIF: records {requester, burst length} per accepted
// command and steers returning read beats to that requester's response port in order.
module mcif_rsp_route2 #(
    parameter int DW    = 32,
    parameter int LEN_W = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_fire,
    input  logic             cmd_id,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             tag_full,
    output logic             tag_empty,
    input  logic             mem_rd_valid,
    input  logic [DW-1:0]    mem_rd_data,
    output logic             mem_rd_ready,
    output logic             rsp0_valid,
    output logic [DW-1:0]    rsp0_data,
    output logic             rsp0_last,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    output logic [DW-1:0]    rsp1_data,
    output logic             rsp1_last,
    input  logic             rsp1_ready,
    output logic             err_ovf,
    output logic             err_unexp
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             id_mem  [DEPTH];
    logic [LEN_W-1:0] len_mem [DEPTH];
    logic [LEN_W-1:0] beat_cnt;

    logic             head_id;
    logic [LEN_W-1:0] head_len;
    logic             sel_ready;
    logic             push;
    logic             beat_fire;
    logic             beat_last;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign tag_empty = (wr_ptr == rd_ptr);
    assign tag_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign head_id   = id_mem[rd_ptr[AW-1:0]];
    assign head_len  = len_mem[rd_ptr[AW-1:0]];

    assign sel_ready    = head_id ? rsp1_ready : rsp0_ready;
    assign mem_rd_ready = ~tag_empty & sel_ready;
    assign beat_fire    = mem_rd_valid & mem_rd_ready;
    assign beat_last    = (beat_cnt == head_len);
    assign push         = cmd_fire & ~tag_full;

    assign rsp0_valid = mem_rd_valid & ~tag_empty & ~head_id;
    assign rsp1_valid = mem_rd_valid & ~tag_empty & head_id;
    assign rsp0_data  = mem_rd_data;
    assign rsp1_data  = mem_rd_data;
    assign rsp0_last  = rsp0_valid & beat_last;
    assign rsp1_last  = rsp1_valid & beat_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_mem[i]  <= 1'b0;
                len_mem[i] <= '0;
            end
        end else begin
            // Full is judged before this cycle's pop, so a pop never frees room for a same-cycle push.
            if (push) begin
                id_mem[wr_ptr[AW-1:0]]  <= cmd_id;
                len_mem[wr_ptr[AW-1:0]] <= cmd_len;
                wr_ptr                  <= wr_ptr + (AW+1)'(1);
            end
            if (beat_fire) begin
                if (beat_last) begin
                    beat_cnt <= '0;
                    rd_ptr   <= rd_ptr + (AW+1)'(1);
                end else begin
                    beat_cnt <= beat_cnt + LEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf   <= 1'b0;
            err_unexp <= 1'b0;
        end else begin
            if (cmd_fire && tag_full)
                err_ovf <= 1'b1;
            if (mem_rd_valid && tag_empty)
                err_unexp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mcif_rsp_route2.sv
// Scoreboard bench for mcif_rsp_route2: a command-queue model predicts port, last and
// readiness for every driven beat; the monitor compares each accepted response beat.
module tb_mcif_rsp_route2;
    localparam int DW    = 32;
    localparam int LEN_W = 4;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_fire;
    logic             cmd_id;
    logic [LEN_W-1:0] cmd_len;
    logic             tag_full;
    logic             tag_empty;
    logic             mem_rd_valid;
    logic [DW-1:0]    mem_rd_data;
    logic             mem_rd_ready;
    logic             rsp0_valid;
    logic [DW-1:0]    rsp0_data;
    logic             rsp0_last;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic [DW-1:0]    rsp1_data;
    logic             rsp1_last;
    logic             rsp1_ready;
    logic             err_ovf;
    logic             err_unexp;

    mcif_rsp_route2 #(.DW(DW), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_fire(cmd_fire), .cmd_id(cmd_id), .cmd_len(cmd_len),
        .tag_full(tag_full), .tag_empty(tag_empty),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_rd_ready(mem_rd_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_last(rsp0_last), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_last(rsp1_last), .rsp1_ready(rsp1_ready),
        .err_ovf(err_ovf), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             id;
        logic [LEN_W-1:0] len;
    } cmd_t;

    typedef struct {
        logic          port;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    cmd_t             mq[$];
    beat_t            sb[$];
    logic [LEN_W-1:0] m_cnt;
    logic             m_ovf;
    logic             m_unexp;
    int               n_vec = 0;
    int               n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".tag_full"},  tag_full,  mq.size() == DEPTH);
        chk({tag, ".tag_empty"}, tag_empty, mq.size() == 0);
        chk({tag, ".err_ovf"},   err_ovf,   m_ovf);
        chk({tag, ".err_unexp"}, err_unexp, m_unexp);
    endtask

    task automatic model_clear();
        mq.delete();
        sb.delete();
        m_cnt   = '0;
        m_ovf   = 1'b0;
        m_unexp = 1'b0;
    endtask

    task automatic take_beat(input logic port, input logic last, input logic [DW-1:0] data);
        beat_t e;
        chk("beat_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("beat_port", port, e.port);
            chk("beat_last", last, e.last);
            chk("beat_data", data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid && rsp0_ready) take_beat(1'b0, rsp0_last, rsp0_data);
            if (rsp1_valid && rsp1_ready) take_beat(1'b1, rsp1_last, rsp1_data);
        end
    end

    // One clock of stimulus; entered and left at posedge+1 with command/beat inputs idle.
    task automatic step(input logic cf, input logic cid, input logic [LEN_W-1:0] clen,
                        input logic bv, input logic [DW-1:0] bd);
        logic pred_rdy;
        logic last;
        logic full;
        cmd_t c;
        cmd_fire     = cf;
        cmd_id       = cid;
        cmd_len      = clen;
        mem_rd_valid = bv;
        mem_rd_data  = bd;
        pred_rdy = (mq.size() != 0) && (mq[0].id ? rsp1_ready : rsp0_ready);
        last     = (mq.size() != 0) && (m_cnt == mq[0].len);
        if (bv && pred_rdy) sb.push_back('{port: mq[0].id, last: last, data: bd});
        @(negedge clk);
        chk("mem_rd_ready", mem_rd_ready, pred_rdy);
        @(posedge clk);
        #1;
        full = (mq.size() == DEPTH);
        if (cf && full) m_ovf = 1'b1;
        if (bv && mq.size() == 0) m_unexp = 1'b1;
        if (bv && pred_rdy) begin
            if (last) begin
                void'(mq.pop_front());
                m_cnt = '0;
            end else begin
                m_cnt = m_cnt + 1'b1;
            end
        end
        if (cf && !full) begin
            c.id  = cid;
            c.len = clen;
            mq.push_back(c);
        end
        cmd_fire     = 1'b0;
        mem_rd_valid = 1'b0;
    endtask

    task automatic push_cmd(input logic cid, input logic [LEN_W-1:0] clen);
        step(1'b1, cid, clen, 1'b0, '0);
    endtask

    task automatic beat(input logic [DW-1:0] bd);
        step(1'b0, 1'b0, '0, 1'b1, bd);
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd_fire     = 1'b0;
        cmd_id       = 1'b0;
        cmd_len      = '0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        rsp0_ready   = 1'b1;
        rsp1_ready   = 1'b1;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        chk_flags("reset");
        chk("reset.mem_rd_ready", mem_rd_ready, 0);
        chk("reset.rsp0_valid", rsp0_valid, 0);
        chk("reset.rsp1_valid", rsp1_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single 4-beat burst to port 0
        push_cmd(1'b0, 4'd3);
        for (int i = 0; i < 4; i++) beat(32'hD000_0000 + i);
        chk_flags("t1");
        chk("t1.sb_drained", sb.size(), 0);

        // interleaved requesters, order preserved
        push_cmd(1'b1, 4'd0);
        push_cmd(1'b0, 4'd1);
        push_cmd(1'b1, 4'd0);
        for (int i = 0; i < 4; i++) beat(32'hA5A5_0010 + i);
        chk_flags("t2");
        chk("t2.sb_drained", sb.size(), 0);

        // head port stalled: other port's ready must not let beats through
        push_cmd(1'b0, 4'd1);
        beat(32'h3333_0000);
        rsp0_ready = 1'b0;
        for (int i = 0; i < 5; i++) beat(32'h3333_0001);
        rsp0_ready = 1'b1;
        beat(32'h3333_0001);
        chk_flags("t3");
        chk("t3.sb_drained", sb.size(), 0);

        // fill, overflow, full+pop+push rejection, push+pop at 7, refill
        for (int i = 0; i < DEPTH; i++) push_cmd(i[0], 4'd0);
        chk_flags("t4.fill");
        push_cmd(1'b1, 4'd0);
        chk_flags("t4.ovf");
        step(1'b1, 1'b1, 4'd0, 1'b1, 32'h4444_0000);
        chk_flags("t4.full_pop");
        step(1'b1, 1'b0, 4'd2, 1'b1, 32'h4444_0001);
        chk_flags("t4.push_pop");
        push_cmd(1'b1, 4'd0);
        chk_flags("t4.refill");
        for (int i = 0; i < 16 && mq.size() > 0; i++) beat(32'h4444_1000 + i);
        chk_flags("t4.drain");
        chk("t4.sb_drained", sb.size(), 0);

        // beat with nothing outstanding
        beat(32'h5555_0000);
        chk_flags("t5.unexp");
        step(1'b0, 1'b0, '0, 1'b0, '0);
        chk_flags("t5.sticky");

        // async reset in the middle of a burst
        push_cmd(1'b0, 4'd3);
        beat(32'h6666_0000);
        beat(32'h6666_0001);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'h6666_0002;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk_flags("t6.rst");
        chk("t6.rst.mem_rd_ready", mem_rd_ready, 0);
        chk("t6.rst.rsp0_valid", rsp0_valid, 0);
        chk("t6.rst.rsp0_last", rsp0_last, 0);
        mem_rd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_cmd(1'b1, 4'd1);
        beat(32'h7777_0000);
        beat(32'h7777_0001);
        chk_flags("t6.after");
        chk("t6.sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
